// File: rtl/axi_sram_slave.sv
// AXI3 slave backed by an internal word memory; independent read and write FSMs, one burst each.
// Optional macro AXI_SLAVE_WRAP_EN enables WRAP bursts; without it WRAP is answered with SLVERR.
module axi_sram_slave #(
  parameter int MEM_ADDR_W = 12
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  io_axi_arid,
  input  logic [31:0] io_axi_araddr,
  input  logic [7:0]  io_axi_arlen,
  input  logic [2:0]  io_axi_arsize,
  input  logic [1:0]  io_axi_arburst,
  input  logic [1:0]  io_axi_arlock,
  input  logic [3:0]  io_axi_arcache,
  input  logic [2:0]  io_axi_arprot,
  input  logic        io_axi_arvalid,
  output logic        io_axi_arready,
  output logic [3:0]  io_axi_rid,
  output logic [31:0] io_axi_rdata,
  output logic [1:0]  io_axi_rresp,
  output logic        io_axi_rlast,
  output logic        io_axi_rvalid,
  input  logic        io_axi_rready,
  input  logic [3:0]  io_axi_awid,
  input  logic [31:0] io_axi_awaddr,
  input  logic [7:0]  io_axi_awlen,
  input  logic [2:0]  io_axi_awsize,
  input  logic [1:0]  io_axi_awburst,
  input  logic [1:0]  io_axi_awlock,
  input  logic [3:0]  io_axi_awcache,
  input  logic [2:0]  io_axi_awprot,
  input  logic        io_axi_awvalid,
  output logic        io_axi_awready,
  input  logic [3:0]  io_axi_wid,
  input  logic [31:0] io_axi_wdata,
  input  logic [3:0]  io_axi_wstrb,
  input  logic        io_axi_wlast,
  input  logic        io_axi_wvalid,
  output logic        io_axi_wready,
  output logic [3:0]  io_axi_bid,
  output logic [1:0]  io_axi_bresp,
  output logic        io_axi_bvalid,
  input  logic        io_axi_bready,
  output logic [2:0]  dbg_state
);
  // Handshake rule: a transfer happens on a rising edge where valid and ready are both 1;
  // valid and its payload are held until that edge, ready never waits on valid.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {R_IDLE, R_BURST} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  logic [31:0] mem [0:(1<<MEM_ADDR_W)-1];

  r_state_t    r_state, r_state_next;
  w_state_t    w_state, w_state_next;
  logic [31:0] r_addr, r_next, r_step, w_addr, w_next, w_step;
  logic [7:0]  r_len, r_beat, w_len, w_beat;
  logic [2:0]  r_size, w_size;
  logic [1:0]  r_burst, w_burst;
  logic        r_err, w_err, w_last_err;
  logic        ar_err, aw_err, ar_wrap_err, aw_wrap_err;
  logic        ar_hs, r_hs, aw_hs, w_hs, w_final;
  logic        unused_inputs;

  assign unused_inputs = ^{io_axi_arlock, io_axi_arcache, io_axi_arprot,
                           io_axi_awlock, io_axi_awcache, io_axi_awprot, io_axi_wid};

`ifdef AXI_SLAVE_WRAP_EN
  assign ar_wrap_err = (io_axi_arburst == 2'b10) &&
                       !(io_axi_arlen inside {8'd1, 8'd3, 8'd7, 8'd15});
  assign aw_wrap_err = (io_axi_awburst == 2'b10) &&
                       !(io_axi_awlen inside {8'd1, 8'd3, 8'd7, 8'd15});
`else
  assign ar_wrap_err = (io_axi_arburst == 2'b10);
  assign aw_wrap_err = (io_axi_awburst == 2'b10);
`endif
  assign ar_err = (io_axi_arsize > 3'd2) || (io_axi_arburst == 2'b11) || ar_wrap_err;
  assign aw_err = (io_axi_awsize > 3'd2) || (io_axi_awburst == 2'b11) || aw_wrap_err;

  assign ar_hs   = io_axi_arvalid & io_axi_arready;
  assign r_hs    = io_axi_rvalid & io_axi_rready;
  assign aw_hs   = io_axi_awvalid & io_axi_awready;
  assign w_hs    = io_axi_wvalid & io_axi_wready;
  assign w_final = (w_beat == w_len);
  assign dbg_state = {w_state, r_state};

  // Next beat address; WRAP keeps the block base and wraps the offset inside the block.
  always_comb begin
    r_step = 32'd1 << r_size;
    r_next = r_addr;
    case (r_burst)
      2'b01: r_next = r_addr + r_step;
`ifdef AXI_SLAVE_WRAP_EN
      2'b10: r_next = (r_addr & ~((r_step * ({24'd0, r_len} + 32'd1)) - 32'd1)) |
                      ((r_addr + r_step) & ((r_step * ({24'd0, r_len} + 32'd1)) - 32'd1));
`endif
      default: r_next = r_addr;
    endcase
  end

  always_comb begin
    w_step = 32'd1 << w_size;
    w_next = w_addr;
    case (w_burst)
      2'b01: w_next = w_addr + w_step;
`ifdef AXI_SLAVE_WRAP_EN
      2'b10: w_next = (w_addr & ~((w_step * ({24'd0, w_len} + 32'd1)) - 32'd1)) |
                      ((w_addr + w_step) & ((w_step * ({24'd0, w_len} + 32'd1)) - 32'd1));
`endif
      default: w_next = w_addr;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= R_IDLE;
    else       r_state <= r_state_next;
  end

  always_comb begin
    r_state_next   = r_state;
    io_axi_arready = 1'b0;
    io_axi_rvalid  = 1'b0;
    case (r_state)
      R_IDLE: begin
        io_axi_arready = !reset;
        if (io_axi_arvalid && !reset) r_state_next = R_BURST;
      end
      R_BURST: begin
        io_axi_rvalid = !reset;
        if (io_axi_rready && (r_beat == r_len)) r_state_next = R_IDLE;
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  // Read data is fetched one edge ahead so it stays stable while rready stalls.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr <= '0; r_len <= '0; r_size <= '0; r_burst <= '0; r_beat <= '0; r_err <= 1'b0;
      io_axi_rid <= '0; io_axi_rdata <= '0; io_axi_rresp <= '0; io_axi_rlast <= 1'b0;
    end else if (ar_hs) begin
      r_addr       <= io_axi_araddr;
      r_len        <= io_axi_arlen;
      r_size       <= io_axi_arsize;
      r_burst      <= io_axi_arburst;
      r_beat       <= '0;
      r_err        <= ar_err;
      io_axi_rid   <= io_axi_arid;
      io_axi_rdata <= ar_err ? 32'd0 : mem[io_axi_araddr[MEM_ADDR_W+1:2]];
      io_axi_rresp <= ar_err ? RESP_SLVERR : RESP_OKAY;
      io_axi_rlast <= (io_axi_arlen == 8'd0);
    end else if (r_hs && (r_beat != r_len)) begin
      r_addr       <= r_next;
      r_beat       <= r_beat + 8'd1;
      io_axi_rdata <= r_err ? 32'd0 : mem[r_next[MEM_ADDR_W+1:2]];
      io_axi_rlast <= ((r_beat + 8'd1) == r_len);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) w_state <= W_IDLE;
    else       w_state <= w_state_next;
  end

  always_comb begin
    w_state_next   = w_state;
    io_axi_awready = 1'b0;
    io_axi_wready  = 1'b0;
    io_axi_bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        io_axi_awready = !reset;
        if (io_axi_awvalid && !reset) w_state_next = W_DATA;
      end
      W_DATA: begin
        io_axi_wready = !reset;
        if (io_axi_wvalid && !reset && w_final) w_state_next = W_RESP;
      end
      W_RESP: begin
        io_axi_bvalid = !reset;
        if (io_axi_bready && !reset) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  // Burst length follows awlen; wlast is only compared against the final-beat position.
  always_ff @(posedge clock) begin
    if (reset) begin
      w_addr <= '0; w_len <= '0; w_size <= '0; w_burst <= '0; w_beat <= '0;
      w_err <= 1'b0; w_last_err <= 1'b0; io_axi_bid <= '0; io_axi_bresp <= '0;
    end else if (aw_hs) begin
      w_addr     <= io_axi_awaddr;
      w_len      <= io_axi_awlen;
      w_size     <= io_axi_awsize;
      w_burst    <= io_axi_awburst;
      w_beat     <= '0;
      w_err      <= aw_err;
      w_last_err <= 1'b0;
      io_axi_bid <= io_axi_awid;
    end else if (w_hs) begin
      w_addr     <= w_next;
      w_beat     <= w_beat + 8'd1;
      w_last_err <= w_last_err | (io_axi_wlast != w_final);
      if (w_final)
        io_axi_bresp <= (w_err || w_last_err || (io_axi_wlast != w_final)) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  always_ff @(posedge clock) begin
    if (w_hs && !w_err) begin
      for (int i = 0; i < 4; i++)
        if (io_axi_wstrb[i]) mem[w_addr[MEM_ADDR_W+1:2]][8*i +: 8] <= io_axi_wdata[8*i +: 8];
    end
  end
endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomized bench for axi_sram_slave with a byte-level memory model and per-beat checking.
// Honors AXI_SLAVE_WRAP_EN the same way as the design build.
module tb_axi_sram_slave;
`ifdef AXI_SLAVE_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  io_axi_arid, io_axi_rid, io_axi_awid, io_axi_wid, io_axi_bid;
  logic [31:0] io_axi_araddr, io_axi_rdata, io_axi_awaddr, io_axi_wdata;
  logic [7:0]  io_axi_arlen, io_axi_awlen;
  logic [2:0]  io_axi_arsize, io_axi_awsize, io_axi_arprot, io_axi_awprot;
  logic [1:0]  io_axi_arburst, io_axi_awburst, io_axi_arlock, io_axi_awlock;
  logic [3:0]  io_axi_arcache, io_axi_awcache, io_axi_wstrb;
  logic [1:0]  io_axi_rresp, io_axi_bresp;
  logic        io_axi_arvalid, io_axi_arready, io_axi_rlast, io_axi_rvalid, io_axi_rready;
  logic        io_axi_awvalid, io_axi_awready, io_axi_wlast, io_axi_wvalid, io_axi_wready;
  logic        io_axi_bvalid, io_axi_bready;
  logic [2:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] ref_mem [4096];
  logic [31:0] wbuf_data [16];
  logic [3:0]  wbuf_strb [16];
  logic [31:0] exp_q [$];

  always #5 clock = ~clock;

  axi_sram_slave dut (
    .clock(clock), .reset(reset),
    .io_axi_arid(io_axi_arid), .io_axi_araddr(io_axi_araddr), .io_axi_arlen(io_axi_arlen),
    .io_axi_arsize(io_axi_arsize), .io_axi_arburst(io_axi_arburst), .io_axi_arlock(io_axi_arlock),
    .io_axi_arcache(io_axi_arcache), .io_axi_arprot(io_axi_arprot),
    .io_axi_arvalid(io_axi_arvalid), .io_axi_arready(io_axi_arready),
    .io_axi_rid(io_axi_rid), .io_axi_rdata(io_axi_rdata), .io_axi_rresp(io_axi_rresp),
    .io_axi_rlast(io_axi_rlast), .io_axi_rvalid(io_axi_rvalid), .io_axi_rready(io_axi_rready),
    .io_axi_awid(io_axi_awid), .io_axi_awaddr(io_axi_awaddr), .io_axi_awlen(io_axi_awlen),
    .io_axi_awsize(io_axi_awsize), .io_axi_awburst(io_axi_awburst), .io_axi_awlock(io_axi_awlock),
    .io_axi_awcache(io_axi_awcache), .io_axi_awprot(io_axi_awprot),
    .io_axi_awvalid(io_axi_awvalid), .io_axi_awready(io_axi_awready),
    .io_axi_wid(io_axi_wid), .io_axi_wdata(io_axi_wdata), .io_axi_wstrb(io_axi_wstrb),
    .io_axi_wlast(io_axi_wlast), .io_axi_wvalid(io_axi_wvalid), .io_axi_wready(io_axi_wready),
    .io_axi_bid(io_axi_bid), .io_axi_bresp(io_axi_bresp), .io_axi_bvalid(io_axi_bvalid),
    .io_axi_bready(io_axi_bready), .dbg_state(dbg_state)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_err(input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    if (size > 3'd2 || burst == 2'b11) return 1'b1;
    if (burst == 2'b10) return !WRAP_EN || !(len == 1 || len == 3 || len == 7 || len == 15);
    return 1'b0;
  endfunction

  // Byte address of beat k, from the burst rules directly (offset arithmetic, not stepping).
  function automatic logic [31:0] beat_addr(input logic [31:0] addr, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst, input int k);
    logic [31:0] step, wb, base;
    step = 32'd1 << size;
    if (burst == 2'b00) return addr;
    if (burst == 2'b01) return addr + 32'(k) * step;
    wb = step * (32'(len) + 32'd1);
    base = addr - (addr % wb);
    return base + ((addr - base + 32'(k) * step) % wb);
  endfunction

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input int stall_pct,
                         input int hold_beat);
    bit err;
    logic [31:0] a, exp_d;
    int wait_n, hold;
    err = model_err(len, size, burst);
    exp_q.delete();
    for (int k = 0; k <= int'(len); k++) begin
      a = beat_addr(addr, len, size, burst, k);
      exp_q.push_back(err ? 32'h0 : ref_mem[a[13:2]]);
    end
    @(negedge clock);
    io_axi_arid = id; io_axi_araddr = addr; io_axi_arlen = len;
    io_axi_arsize = size; io_axi_arburst = burst; io_axi_arvalid = 1'b1;
    wait_n = 0;
    while (!io_axi_arready && wait_n < 50) begin @(negedge clock); wait_n++; end
    check_eq("ar_ready", io_axi_arready, 1);
    @(negedge clock);
    io_axi_arvalid = 1'b0;
    check_eq("r_first_latency", io_axi_rvalid, 1);
    for (int k = 0; k <= int'(len); k++) begin
      exp_d = exp_q.pop_front();
      hold = (k == hold_beat) ? 5 : 0;
      wait_n = 0;
      forever begin
        if (hold > 0) begin io_axi_rready = 1'b0; hold--; end
        else io_axi_rready = ($urandom_range(0, 99) >= stall_pct);
        if (io_axi_rvalid) begin
          check_eq("r_data", io_axi_rdata, exp_d);
          check_eq("r_resp", io_axi_rresp, err ? 2 : 0);
          check_eq("r_last", io_axi_rlast, (k == int'(len)));
          check_eq("r_id", io_axi_rid, id);
          if (io_axi_rready) break;
        end
        wait_n++;
        if (wait_n > 200) begin
          check_eq("r_timeout", io_axi_rvalid, 1);
          io_axi_rready = 1'b0;
          return;
        end
        @(negedge clock);
      end
      @(negedge clock);
    end
    io_axi_rready = 1'b0;
    check_eq("r_done_rvalid", io_axi_rvalid, 0);
    check_eq("r_done_arready", io_axi_arready, 1);
  endtask

  // bad_last_beat < 0: wlast on the true final beat; otherwise wlast only on that beat.
  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int bad_last_beat);
    bit err, last_err, wl;
    logic [31:0] a;
    int wait_n;
    err = model_err(len, size, burst);
    last_err = 1'b0;
    @(negedge clock);
    io_axi_awid = id; io_axi_awaddr = addr; io_axi_awlen = len;
    io_axi_awsize = size; io_axi_awburst = burst; io_axi_awvalid = 1'b1;
    wait_n = 0;
    while (!io_axi_awready && wait_n < 50) begin @(negedge clock); wait_n++; end
    check_eq("aw_ready", io_axi_awready, 1);
    @(negedge clock);
    io_axi_awvalid = 1'b0;
    check_eq("w_first_latency", io_axi_wready, 1);
    for (int k = 0; k <= int'(len); k++) begin
      wl = (bad_last_beat >= 0) ? (k == bad_last_beat) : (k == int'(len));
      if (wl != (k == int'(len))) last_err = 1'b1;
      wait_n = 0;
      forever begin
        io_axi_wvalid = ($urandom_range(0, 3) != 0);
        io_axi_wdata = wbuf_data[k]; io_axi_wstrb = wbuf_strb[k]; io_axi_wlast = wl;
        if (io_axi_wvalid && io_axi_wready) break;
        wait_n++;
        if (wait_n > 200) begin
          check_eq("w_timeout", io_axi_wready, 1);
          io_axi_wvalid = 1'b0;
          return;
        end
        @(negedge clock);
      end
      @(negedge clock);
      if (!err) begin
        a = beat_addr(addr, len, size, burst, k);
        for (int i = 0; i < 4; i++)
          if (wbuf_strb[k][i]) ref_mem[a[13:2]][8*i +: 8] = wbuf_data[k][8*i +: 8];
      end
    end
    io_axi_wvalid = 1'b0;
    io_axi_wlast = 1'b0;
    check_eq("b_latency", io_axi_bvalid, 1);
    wait_n = 0;
    forever begin
      io_axi_bready = ($urandom_range(0, 2) != 0);
      if (io_axi_bvalid) begin
        check_eq("b_id", io_axi_bid, id);
        check_eq("b_resp", io_axi_bresp, (err || last_err) ? 2 : 0);
        if (io_axi_bready) break;
      end
      wait_n++;
      if (wait_n > 200) begin
        check_eq("b_timeout", io_axi_bvalid, 1);
        io_axi_bready = 1'b0;
        return;
      end
      @(negedge clock);
    end
    @(negedge clock);
    io_axi_bready = 1'b0;
    check_eq("b_done_bvalid", io_axi_bvalid, 0);
    check_eq("b_done_awready", io_axi_awready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int sel, bad;

    reset = 1'b1;
    io_axi_arid = '0; io_axi_araddr = '0; io_axi_arlen = '0; io_axi_arsize = '0;
    io_axi_arburst = '0; io_axi_arlock = '0; io_axi_arcache = '0; io_axi_arprot = '0;
    io_axi_arvalid = 1'b0; io_axi_rready = 1'b0;
    io_axi_awid = '0; io_axi_awaddr = '0; io_axi_awlen = '0; io_axi_awsize = '0;
    io_axi_awburst = '0; io_axi_awlock = '0; io_axi_awcache = '0; io_axi_awprot = '0;
    io_axi_awvalid = 1'b0; io_axi_wid = '0; io_axi_wdata = '0; io_axi_wstrb = '0;
    io_axi_wlast = 1'b0; io_axi_wvalid = 1'b0; io_axi_bready = 1'b0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check_eq("rst_arready", io_axi_arready, 0);
    check_eq("rst_awready", io_axi_awready, 0);
    check_eq("rst_wready", io_axi_wready, 0);
    check_eq("rst_rvalid", io_axi_rvalid, 0);
    check_eq("rst_bvalid", io_axi_bvalid, 0);
    check_eq("rst_rdata", io_axi_rdata, 0);
    check_eq("rst_rresp", io_axi_rresp, 0);
    check_eq("rst_rlast", io_axi_rlast, 0);
    check_eq("rst_rid", io_axi_rid, 0);
    check_eq("rst_bid", io_axi_bid, 0);
    check_eq("rst_bresp", io_axi_bresp, 0);
    reset = 1'b0;
    @(negedge clock);
    check_eq("post_rst_arready", io_axi_arready, 1);
    check_eq("post_rst_awready", io_axi_awready, 1);

    // Fill words 0..255 so every later read has a known model value.
    for (int b = 0; b < 16; b++) begin
      for (int k = 0; k < 16; k++) begin wbuf_data[k] = $urandom; wbuf_strb[k] = 4'hF; end
      do_write(4'($urandom_range(0, 15)), 32'(b * 64), 8'd15, 3'd2, 2'b01, -1);
    end

    // INCR write and read back of four words.
    for (int k = 0; k < 4; k++) begin wbuf_data[k] = 32'(8'h11 * (k + 1)); wbuf_strb[k] = 4'hF; end
    do_write(4'h3, 32'h100, 8'd3, 3'd2, 2'b01, -1);
    do_read(4'h5, 32'h100, 8'd3, 3'd2, 2'b01, 0, -1);

    // Byte-lane write over a zero word.
    wbuf_data[0] = 32'h0; wbuf_strb[0] = 4'hF;
    do_write(4'h1, 32'h200, 8'd0, 3'd2, 2'b01, -1);
    wbuf_data[0] = 32'hAABBCCDD; wbuf_strb[0] = 4'b0101;
    do_write(4'h2, 32'h200, 8'd0, 3'd2, 2'b01, -1);
    do_read(4'h7, 32'h200, 8'd0, 3'd2, 2'b01, 0, -1);

    // WRAP read starting mid-block.
    for (int k = 0; k < 4; k++) begin wbuf_data[k] = 32'(k + 1); wbuf_strb[k] = 4'hF; end
    do_write(4'h4, 32'h100, 8'd3, 3'd2, 2'b01, -1);
    do_read(4'h9, 32'h108, 8'd3, 3'd2, 2'b10, 0, -1);

    // Five-cycle rready stall on beat 2.
    do_read(4'hA, 32'h0, 8'd7, 3'd2, 2'b01, 0, 2);

    // Early wlast, then an oversize read.
    for (int k = 0; k < 2; k++) begin wbuf_data[k] = $urandom; wbuf_strb[k] = 4'hF; end
    do_write(4'hB, 32'h300, 8'd1, 3'd2, 2'b01, 0);
    do_read(4'hC, 32'h300, 8'd1, 3'd2, 2'b01, 30, -1);
    do_read(4'hD, 32'h300, 8'd3, 3'd3, 2'b01, 30, -1);

    // Reset while beat 2 of an 8-beat read is on the bus.
    @(negedge clock);
    io_axi_arid = 4'h6; io_axi_araddr = 32'h40; io_axi_arlen = 8'd7;
    io_axi_arsize = 3'd2; io_axi_arburst = 2'b01; io_axi_arvalid = 1'b1;
    @(negedge clock);
    io_axi_arvalid = 1'b0;
    io_axi_rready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check_eq("rst_mid_beat2_valid", io_axi_rvalid, 1);
    check_eq("rst_mid_beat2_data", io_axi_rdata, ref_mem[18]);
    io_axi_rready = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    check_eq("rst_mid_rvalid", io_axi_rvalid, 0);
    check_eq("rst_mid_rid", io_axi_rid, 0);
    reset = 1'b0;
    @(negedge clock);
    check_eq("rst_mid_arready", io_axi_arready, 1);
    check_eq("rst_mid_rvalid_after", io_axi_rvalid, 0);
    do_read(4'hE, 32'h40, 8'd7, 3'd2, 2'b01, 20, -1);

    // Random mix with aliased upper address bits.
    for (int t = 0; t < 40; t++) begin
      id = 4'($urandom_range(0, 15));
      size = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      sel = $urandom_range(0, 9);
      burst = (sel < 2) ? 2'b00 : (sel < 7) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
      if (burst == 2'b10) begin
        sel = $urandom_range(0, 4);
        len = (sel == 0) ? 8'd1 : (sel == 1) ? 8'd3 : (sel == 2) ? 8'd7 : (sel == 3) ? 8'd15 : 8'd2;
      end else begin
        len = 8'($urandom_range(0, 15));
      end
      addr = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 32'h1FF));
      if ($urandom_range(0, 1) == 0) begin
        for (int k = 0; k < 16; k++) begin wbuf_data[k] = $urandom; wbuf_strb[k] = 4'($urandom); end
        bad = ($urandom_range(0, 7) == 0) ? $urandom_range(0, int'(len)) : -1;
        do_write(id, addr, len, size, burst, bad);
      end else begin
        do_read(id, addr, len, size, burst, $urandom_range(0, 50), -1);
      end
    end

    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
